sha256_stream_hasher: RTL and testbench

Multi-byte-per-beat SHA-256/SHA-224 message front end with a valid/ready input stream and a valid/ready digest output.
- Accepts IN_BYTES bytes per beat and performs all FIPS 180-4 padding and length insertion, including the 56..64-byte extra-block case.
- Chains intermediate hash state through an external compression core port and presents the final digest.
- Successor to the single-byte processor: adds parametrised beat width, backpressure on both sides, partial last beat, empty-message support and a SHA-224 mode.

---
 rtl/sha256_pkg.sv | 39 +++
 rtl/sha256_block_buf.sv | 84 ++++++++
 rtl/sha256_stream_hasher.sv | 188 ++++++++++++++++++
 tb/tb_sha256_stream_hasher.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 / SHA-224 shared definitions for the stream hasher.
// Holds:
//   - the two initial hash values;
//   - block and word geometry;
//   - the FSM state encoding;
//   - IV selection and digest truncation helpers.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int HASH_W      = 256;
  localparam int BLOCK_W     = 512;
  localparam int BLOCK_BYTES = 64;
  localparam int LEN_FIELD_W = 64;
  localparam int LEN_OFFSET  = 56;

  localparam logic [HASH_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [HASH_W-1:0] SHA224_IV =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_PAD   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  function automatic logic [HASH_W-1:0] select_iv(input logic m224);
    return m224 ? SHA224_IV : SHA256_IV;
  endfunction

  // SHA-224 keeps H0..H6 and zeroes the final word slot.
  function automatic logic [HASH_W-1:0] truncate_digest(input logic m224,
                                                        input logic [HASH_W-1:0] h);
    return m224 ? {h[HASH_W-1:WORD_W], {WORD_W{1'b0}}} : h;
  endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 64-byte message block buffer.
// Ports:
//   clk, rst           clock, async active-high reset (buffer cleared)
//   wr_en/wr_pos       write one beat starting at byte wr_pos
//   wr_data/wr_count   beat bytes (earliest byte in MSBs); bytes >= wr_count become 0x00
//   pad_en/pad_pos     write 0x80 at pad_pos and zero everything after it
//   pad_len_en         together with pad_en, also put the length into bytes 56..63
//   len_blk_en         replace the block with an all-zero length-only block
//   len_blk_80         put 0x80 in byte 0 of that length-only block
//   len_bits           64-bit big-endian message length in bits
//   block              buffer contents, byte 0 at [511:504]
module sha256_block_buf
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int CNT_W    = $clog2(IN_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [5:0]             wr_pos,
  input  logic [IN_BYTES*8-1:0]  wr_data,
  input  logic [CNT_W-1:0]       wr_count,
  input  logic                   pad_en,
  input  logic [6:0]             pad_pos,
  input  logic                   pad_len_en,
  input  logic                   len_blk_en,
  input  logic                   len_blk_80,
  input  logic [LEN_FIELD_W-1:0] len_bits,
  output logic [BLOCK_W-1:0]     block
);

  logic [7:0] bytes_q [BLOCK_BYTES];
  logic [7:0] bytes_d [BLOCK_BYTES];

  // The three update kinds are never requested in the same cycle; the
  // priority order below only matters for robustness.
  always_comb begin
    bytes_d = bytes_q;
    if (wr_en) begin
      for (int j = 0; j < IN_BYTES; j++) begin
        if (CNT_W'(j) < wr_count)
          bytes_d[wr_pos + 6'(j)] = wr_data[IN_BYTES*8-1-8*j -: 8];
        else
          bytes_d[wr_pos + 6'(j)] = 8'h00;
      end
    end else if (pad_en) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (7'(i) == pad_pos)
          bytes_d[i] = 8'h80;
        else if (7'(i) > pad_pos)
          bytes_d[i] = 8'h00;
      end
      if (pad_len_en) begin
        for (int i = 0; i < 8; i++)
          bytes_d[LEN_OFFSET+i] = len_bits[LEN_FIELD_W-1-8*i -: 8];
      end
    end else if (len_blk_en) begin
      for (int i = 0; i < BLOCK_BYTES; i++)
        bytes_d[i] = 8'h00;
      if (len_blk_80)
        bytes_d[0] = 8'h80;
      for (int i = 0; i < 8; i++)
        bytes_d[LEN_OFFSET+i] = len_bits[LEN_FIELD_W-1-8*i -: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_BYTES; i++)
        bytes_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < BLOCK_BYTES; i++)
        bytes_q[i] <= bytes_d[i];
    end
  end

  always_comb begin
    block = '0;
    for (int i = 0; i < BLOCK_BYTES; i++)
      block[BLOCK_W-1-8*i -: 8] = bytes_q[i];
  end

endmodule

// File: rtl/sha256_stream_hasher.sv
// SHA-256 / SHA-224 streaming message front end.
// Takes IN_BYTES-wide beats, pads the message, chains the hash state through
// an external compression core and presents the final digest.
// Ports:
//   clk, rst                       clock, async active-high reset
//   s_valid/s_ready/s_data         input beat stream (earliest byte in MSBs)
//   s_last/s_nbytes                end of message, valid bytes on the last beat
//   mode_224                       SHA-224 select, taken from the first beat
//   core_start/core_block/core_iv  compression request to the core
//   core_done/core_digest          compression result (feed-forward applied)
//   digest/digest_valid/digest_ready  final hash handshake
//   busy                           message in progress
module sha256_stream_hasher
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [IN_BYTES*8-1:0]         s_data,
  input  logic                          s_last,
  input  logic [$clog2(IN_BYTES+1)-1:0] s_nbytes,
  input  logic                          mode_224,
  output logic                          core_start,
  output logic [BLOCK_W-1:0]            core_block,
  output logic [HASH_W-1:0]             core_iv,
  input  logic                          core_done,
  input  logic [HASH_W-1:0]             core_digest,
  output logic [HASH_W-1:0]             digest,
  output logic                          digest_valid,
  input  logic                          digest_ready,
  output logic                          busy
);

  localparam int CNT_W = $clog2(IN_BYTES + 1);

  state_t             state;
  logic [6:0]         byte_cnt;
  logic [LEN_W-1:0]   len;
  logic [HASH_W-1:0]  h;
  logic               mode_q;
  logic               seen_last;
  logic               need_len;
  logic               pad80_pending;

  logic               accept;
  logic [CNT_W-1:0]   beat_cnt;
  logic [6:0]         next_cnt;
  logic [LEN_W-1:0]   beat_bits;

  assign accept  = s_valid && s_ready;
  assign core_iv = h;

  // Bytes contributed by the current beat; oversize s_nbytes saturates.
  always_comb begin
    beat_cnt = CNT_W'(IN_BYTES);
    if (s_last && (s_nbytes < CNT_W'(IN_BYTES)))
      beat_cnt = s_nbytes;
  end

  assign next_cnt  = byte_cnt + 7'(beat_cnt);
  assign beat_bits = LEN_W'(beat_cnt) << 3;

  sha256_block_buf #(
    .IN_BYTES (IN_BYTES),
    .CNT_W    (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (accept),
    .wr_pos     (byte_cnt[5:0]),
    .wr_data    (s_data),
    .wr_count   (beat_cnt),
    .pad_en     ((state == ST_PAD) && (byte_cnt < 7'd64)),
    .pad_pos    (byte_cnt),
    .pad_len_en (byte_cnt <= 7'd55),
    .len_blk_en ((state == ST_WAIT) && core_done && need_len),
    .len_blk_80 (pad80_pending),
    .len_bits   (64'(len)),
    .block      (core_block)
  );

  // s_ready and core_start are registered, so they are set on the
  // transition into LOAD / ISSUE respectively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_LOAD;
      byte_cnt      <= '0;
      len           <= '0;
      h             <= SHA256_IV;
      mode_q        <= 1'b0;
      seen_last     <= 1'b0;
      need_len      <= 1'b0;
      pad80_pending <= 1'b0;
      s_ready       <= 1'b0;
      core_start    <= 1'b0;
      digest        <= '0;
      digest_valid  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            byte_cnt <= next_cnt;
            len      <= len + beat_bits;
            if (!busy) begin
              busy   <= 1'b1;
              mode_q <= mode_224;
              h      <= select_iv(mode_224);
            end
            if (s_last) begin
              seen_last <= 1'b1;
              s_ready   <= 1'b0;
              state     <= ST_PAD;
            end else if (next_cnt == 7'd64) begin
              byte_cnt   <= '0;
              s_ready    <= 1'b0;
              core_start <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end

        // A full final block is sent as-is; the 0x80 and length follow in an
        // extra block. 56..63 bytes leave no room for the length field.
        ST_PAD: begin
          if (byte_cnt == 7'd64) begin
            need_len      <= 1'b1;
            pad80_pending <= 1'b1;
          end else if (byte_cnt >= 7'd56) begin
            need_len      <= 1'b1;
            pad80_pending <= 1'b0;
          end else begin
            need_len      <= 1'b0;
            pad80_pending <= 1'b0;
          end
          core_start <= 1'b1;
          state      <= ST_ISSUE;
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (core_done) begin
            h <= core_digest;
            if (need_len) begin
              need_len      <= 1'b0;
              pad80_pending <= 1'b0;
              core_start    <= 1'b1;
              state         <= ST_ISSUE;
            end else if (seen_last) begin
              digest       <= truncate_digest(mode_q, core_digest);
              digest_valid <= 1'b1;
              state        <= ST_OUT;
            end else begin
              s_ready <= 1'b1;
              state   <= ST_LOAD;
            end
          end
        end

        ST_OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            seen_last    <= 1'b0;
            len          <= '0;
            byte_cnt     <= '0;
            s_ready      <= 1'b1;
            state        <= ST_LOAD;
          end
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Self-checking bench for sha256_stream_hasher (IN_BYTES=4).
// A behavioural SHA-256 compression core answers core_start after 64 cycles.
// Expected digests are pushed to a scoreboard queue when a message is sent
// and popped when the DUT presents its digest.
module tb_sha256_stream_hasher;

  localparam int IN_BYTES = 4;
  localparam int LEN_W    = 64;
  localparam int CNT_W    = $clog2(IN_BYTES + 1);

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DIG_A64 =
    256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;
  localparam logic [255:0] DIG_224 =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] IV_224 =
    256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam string STR_TWO = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [IN_BYTES*8-1:0] s_data = '0;
  logic                  s_last = 1'b0;
  logic [CNT_W-1:0]      s_nbytes = '0;
  logic                  mode_224 = 1'b0;
  logic                  core_start;
  logic [511:0]          core_block;
  logic [255:0]          core_iv;
  logic                  core_done = 1'b0;
  logic [255:0]          core_digest = '0;
  logic [255:0]          digest;
  logic                  digest_valid;
  logic                  digest_ready = 1'b0;
  logic                  busy;

  int vectors = 0;
  int miscompares = 0;
  int start_count = 0;
  logic [255:0] exp_q [$];
  logic [511:0] blk_log [$];
  logic [255:0] iv_log [$];
  logic [7:0]   msg [0:127];

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_stream_hasher #(
    .IN_BYTES (IN_BYTES),
    .LEN_W    (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_nbytes     (s_nbytes),
    .mode_224     (mode_224),
    .core_start   (core_start),
    .core_block   (core_block),
    .core_iv      (core_iv),
    .core_done    (core_done),
    .core_digest  (core_digest),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, hh} = iv;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + iv[255:224], b + iv[223:192], c + iv[191:160], d + iv[159:128],
            e + iv[127:96], f + iv[95:64], g + iv[63:32], hh + iv[31:0]};
  endfunction

  // Behavioural compression core: 64-cycle latency, dropped by reset.
  initial begin
    int cnt;
    logic [255:0] res;
    cnt = 0;
    res = '0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        cnt = 0;
        core_done = 1'b0;
      end else begin
        core_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_done = 1'b1;
            core_digest = res;
          end
        end
        if (core_start) begin
          start_count++;
          blk_log.push_back(core_block);
          iv_log.push_back(core_iv);
          res = sha_compress(core_iv, core_block);
          cnt = 64;
        end
      end
    end
  end

  task automatic load_string(input string s);
    for (int i = 0; i < s.len(); i++) msg[i] = s[i];
  endtask

  task automatic present_beat(input int n, input int b, input logic m224);
    int nbeats;
    int idx;
    nbeats = (n == 0) ? 1 : (n + IN_BYTES - 1) / IN_BYTES;
    s_valid  = 1'b1;
    mode_224 = m224;
    s_last   = (b == nbeats - 1);
    for (int j = 0; j < IN_BYTES; j++) begin
      idx = b * IN_BYTES + j;
      s_data[IN_BYTES*8-1-8*j -: 8] = (idx < n) ? msg[idx] : 8'h00;
    end
    s_nbytes = s_last ? CNT_W'(n - b * IN_BYTES) : CNT_W'(IN_BYTES);
  endtask

  // Returns at the falling edge after the beat was taken.
  task automatic wait_accept(input string name);
    int guard;
    guard = 0;
    while (!s_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (!s_ready) begin
      miscompares++;
      $display("[TB] FAIL %s accept: s_ready stayed 0 for %0d cycles, required 1", name, guard);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_message(input string name, input int n, input logic m224);
    int nbeats;
    nbeats = (n == 0) ? 1 : (n + IN_BYTES - 1) / IN_BYTES;
    for (int b = 0; b < nbeats; b++) begin
      present_beat(n, b, m224);
      wait_accept(name);
    end
  endtask

  task automatic wait_valid(input string name);
    int guard;
    guard = 0;
    while (!digest_valid && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (!digest_valid) begin
      miscompares++;
      $display("[TB] FAIL %s digest_valid: got 0 after %0d cycles, required 1", name, guard);
    end
  endtask

  task automatic pop_and_check(input string name);
    logic [255:0] exp;
    exp = exp_q.pop_front();
    vectors++;
    if (digest !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s digest: got %h expected %h", name, digest, exp);
    end
  endtask

  task automatic handshake(input string name);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    vectors++;
    if (digest_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s release: got valid=%b busy=%b s_ready=%b expected 0 0 1",
               name, digest_valid, busy, s_ready);
    end
  endtask

  task automatic check_starts(input string name, input int base, input int want);
    vectors++;
    if (start_count - base !== want) begin
      miscompares++;
      $display("[TB] FAIL %s core_start count: got %0d expected %0d", name, start_count - base, want);
    end
  endtask

  task automatic check_block(input string name, input logic [511:0] want);
    vectors++;
    if (blk_log.size() == 0 || blk_log[blk_log.size()-1] !== want) begin
      miscompares++;
      $display("[TB] FAIL %s core_block: got %h expected %h", name,
               (blk_log.size() == 0) ? 512'h0 : blk_log[blk_log.size()-1], want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset s_ready: got %b expected 0", s_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset core_start: got %b expected 0", core_start); end
    if (digest_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset digest_valid: got %b expected 0", digest_valid); end
    if (digest !== 256'h0) begin miscompares++; $display("[TB] FAIL reset digest: got %h expected 0", digest); end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset release s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_abc();
    int base;
    base = start_count;
    load_string("abc");
    exp_q.push_back(DIG_ABC);
    send_message("abc", 3, 1'b0);
    vectors += 2;
    if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL abc latency pad: got core_start=%b expected 0", core_start); end
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL abc busy: got %b expected 1", busy); end
    @(negedge clk);
    vectors++;
    if (core_start !== 1'b1) begin miscompares++; $display("[TB] FAIL abc latency issue: got core_start=%b expected 1", core_start); end
    wait_valid("abc");
    pop_and_check("abc");
    handshake("abc");
    check_starts("abc", base, 1);
    check_block("abc", {32'h61626380, 416'h0, 64'h18});
  endtask

  task automatic test_empty();
    int base;
    base = start_count;
    exp_q.push_back(DIG_EMPTY);
    send_message("empty", 0, 1'b0);
    wait_valid("empty");
    pop_and_check("empty");
    handshake("empty");
    check_starts("empty", base, 1);
    check_block("empty", {8'h80, 504'h0});
  endtask

  task automatic test_len_block();
    int base;
    base = start_count;
    load_string(STR_TWO);
    exp_q.push_back(DIG_TWO);
    send_message("len_block", 56, 1'b0);
    wait_valid("len_block");
    pop_and_check("len_block");
    handshake("len_block");
    check_starts("len_block", base, 2);
    check_block("len_block", {448'h0, 64'h1c0});
  endtask

  task automatic test_full_block();
    int base;
    base = start_count;
    for (int i = 0; i < 64; i++) msg[i] = 8'h61;
    exp_q.push_back(DIG_A64);
    send_message("full_block", 64, 1'b0);
    wait_valid("full_block");
    pop_and_check("full_block");
    handshake("full_block");
    check_starts("full_block", base, 2);
    check_block("full_block", {8'h80, 440'h0, 64'h200});
  endtask

  task automatic test_sha224_hold();
    logic [255:0] held;
    load_string("abc");
    exp_q.push_back(DIG_224);
    send_message("sha224", 3, 1'b1);
    mode_224 = 1'b0;
    wait_valid("sha224");
    pop_and_check("sha224");
    vectors++;
    if (iv_log.size() == 0 || iv_log[iv_log.size()-1] !== IV_224) begin
      miscompares++;
      $display("[TB] FAIL sha224 core_iv: got %h expected %h",
               (iv_log.size() == 0) ? 256'h0 : iv_log[iv_log.size()-1], IV_224);
    end
    held = DIG_224;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (digest_valid !== 1'b1 || digest !== held || s_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sha224 hold cycle %0d: got valid=%b s_ready=%b digest=%h expected 1 0 %h",
                 c, digest_valid, s_ready, digest, held);
      end
    end
    handshake("sha224");
  endtask

  task automatic test_reset_mid();
    int base;
    base = start_count;
    load_string(STR_TWO);
    present_beat(56, 0, 1'b0);
    wait_accept("reset_mid");
    present_beat(56, 1, 1'b0);
    wait_accept("reset_mid");
    present_beat(56, 2, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid async: got s_ready=%b busy=%b expected 0 0", s_ready, busy);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_starts("reset_mid abort", base, 0);
    base = start_count;
    load_string("abc");
    exp_q.push_back(DIG_ABC);
    send_message("reset_mid abc", 3, 1'b0);
    wait_valid("reset_mid abc");
    pop_and_check("reset_mid abc");
    handshake("reset_mid abc");
    check_starts("reset_mid abc", base, 1);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_len_block();
    test_full_block();
    test_sha224_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
